// File: rtl/spi_byte_ctrl.sv
// Byte-level sequencer feeding the ILI9341 SPI shift stage: buffers {last, dc, data}
// requests in a small FIFO and drives load/shift/cs/dc plus a per-bit valid strobe.
module spi_byte_ctrl #(
   parameter int unsigned DW           = 8,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned HOLD_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   input  logic          i_dc,
   input  logic          i_last,
   output logic          o_ready,
   output logic          o_load,
   output logic          o_shift_en,
   output logic [DW-1:0] o_data,
   output logic          o_dc,
   output logic          o_cs,
   output logic          o_bit_valid,
   output logic          o_busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = (DW > 2) ? $clog2(DW) : 1;
   localparam int unsigned TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

   localparam logic [CW-1:0] CNT_START = CW'(DW - 2);
   localparam logic [TW-1:0] TMR_LAST  = TW'(HOLD_TIMEOUT - 1);
   localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_WAIT,
      S_RELEASE
   } state_t;

   state_t         state;
   logic [DW+1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic [CW-1:0]  bit_cnt;
   logic [TW-1:0]  hold_tmr;
   logic           last_r;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic [DW+1:0]  head;

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);
   assign push  = i_valid && !full;
   assign pop   = (state == S_LOAD);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {i_last, i_dc, i_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         hold_tmr    <= '0;
         last_r      <= 1'b0;
         o_bit_valid <= 1'b0;
      end else begin
         // MOSI carries a payload bit in the cycle after every LOAD/SHIFT cycle
         o_bit_valid <= (state == S_LOAD) || (state == S_SHIFT);
         case (state)
            S_IDLE: begin
               if (!empty) state <= S_LOAD;
            end
            S_LOAD: begin
               last_r  <= head[DW+1];
               bit_cnt <= CNT_START;
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               if (bit_cnt == '0) begin
                  if (last_r) begin
                     state <= S_RELEASE;
                  end else if (!empty) begin
                     state <= S_LOAD;
                  end else begin
                     state    <= S_WAIT;
                     hold_tmr <= '0;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            S_WAIT: begin
               if (!empty) begin
                  state    <= S_LOAD;
                  hold_tmr <= '0;
               end else if (hold_tmr == TMR_LAST) begin
                  state    <= S_RELEASE;
                  hold_tmr <= '0;
               end else begin
                  hold_tmr <= hold_tmr + 1'b1;
               end
            end
            S_RELEASE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // RELEASE reuses the load path to park the shift stage at all-ones with CS high
   always_comb begin
      o_load     = 1'b0;
      o_shift_en = 1'b0;
      o_data     = '1;
      o_dc       = 1'b1;
      o_cs       = 1'b1;
      case (state)
         S_LOAD: begin
            o_load     = 1'b1;
            o_shift_en = 1'b1;
            o_cs       = 1'b0;
            o_data     = head[DW-1:0];
            o_dc       = head[DW];
         end
         S_SHIFT: begin
            o_shift_en = 1'b1;
            o_cs       = 1'b0;
         end
         S_WAIT: begin
            o_cs = 1'b0;
         end
         S_RELEASE: begin
            o_load     = 1'b1;
            o_shift_en = 1'b1;
         end
         default: begin
            o_cs = 1'b1;
         end
      endcase
   end

   assign o_ready = !full;
   assign o_busy  = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_spi_byte_ctrl.sv
// Directed self-checking bench for spi_byte_ctrl; outputs sampled on the falling edge,
// cycle 0 is the first falling edge after the first push.
module tb_spi_byte_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_valid = 1'b0;
   logic [7:0] i_data = 8'h00;
   logic       i_dc = 1'b0;
   logic       i_last = 1'b0;
   logic       o_ready;
   logic       o_load;
   logic       o_shift_en;
   logic [7:0] o_data;
   logic       o_dc;
   logic       o_cs;
   logic       o_bit_valid;
   logic       o_busy;
   logic [6:0] obs;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   spi_byte_ctrl #(.DW(8), .DEPTH(4), .HOLD_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_dc(i_dc),
      .i_last(i_last), .o_ready(o_ready), .o_load(o_load), .o_shift_en(o_shift_en),
      .o_data(o_data), .o_dc(o_dc), .o_cs(o_cs), .o_bit_valid(o_bit_valid), .o_busy(o_busy)
   );

   // {load, shift_en, cs, dc, bit_valid, busy, ready}
   assign obs = {o_load, o_shift_en, o_cs, o_dc, o_bit_valid, o_busy, o_ready};

   task automatic test_reset();
      rst = 1'b1;
      #3 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_assert++;
      if (obs !== 7'b0011001) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want %b", obs, 7'b0011001);
      end
      n_assert++;
      if (o_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_data: got %h want ff", o_data);
      end
      rst = 1'b1;
      @(negedge clk);
      n_assert++;
      if (obs !== 7'b0011001) begin
         n_fail++;
         $display("FAIL reset_release_ctrl: got %b want %b", obs, 7'b0011001);
      end
   endtask

   task automatic test_single();
      logic [6:0]  exp, msk;
      logic        ld, sh, cs, bv, busy, dcx, dc_care;
      int unsigned bv_cnt = 0;
      i_valid = 1'b1; i_data = 8'h2A; i_dc = 1'b0; i_last = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (c == 0) i_valid = 1'b0;
         ld   = (c == 1) || (c == 9);
         sh   = (c >= 1) && (c <= 9);
         cs   = !((c >= 1) && (c <= 8));
         bv   = (c >= 2) && (c <= 9);
         busy = (c <= 9);
         dcx  = (c == 1) ? 1'b0 : 1'b1;
         dc_care = !((c >= 2) && (c <= 8));
         exp = {ld, sh, cs, dcx, bv, busy, 1'b1};
         msk = dc_care ? 7'h7F : 7'h77;
         if (o_bit_valid === 1'b1) bv_cnt++;
         n_assert++;
         if ((obs & msk) !== (exp & msk)) begin
            n_fail++;
            $display("FAIL single_ctrl c=%0d: got %b want %b", c, obs & msk, exp & msk);
         end
         if (c == 1 || c == 9) begin
            n_assert++;
            if (o_data !== ((c == 1) ? 8'h2A : 8'hFF)) begin
               n_fail++;
               $display("FAIL single_data c=%0d: got %h want %h", c, o_data,
                        (c == 1) ? 8'h2A : 8'hFF);
            end
         end
      end
      n_assert++;
      if (bv_cnt != 8) begin
         n_fail++;
         $display("FAIL single_bitvalid_len: got %0d want 8", bv_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0]  exp, msk;
      logic        ld, sh, cs, bv, busy, dcx;
      logic [7:0]  dexp;
      int unsigned bv_cnt = 0;
      i_valid = 1'b1; i_data = 8'h2C; i_dc = 1'b0; i_last = 1'b0;
      for (int c = 0; c <= 26; c++) begin
         @(negedge clk);
         ld   = (c == 1) || (c == 9) || (c == 17) || (c == 25);
         sh   = (c >= 1) && (c <= 25);
         cs   = !((c >= 1) && (c <= 24));
         bv   = (c >= 2) && (c <= 25);
         busy = (c <= 25);
         dcx  = (c == 1) ? 1'b0 : 1'b1;
         exp  = {ld, sh, cs, dcx, bv, busy, 1'b1};
         msk  = (ld || c == 0 || c == 26) ? 7'h7F : 7'h77;
         if (o_bit_valid === 1'b1) bv_cnt++;
         n_assert++;
         if ((obs & msk) !== (exp & msk)) begin
            n_fail++;
            $display("FAIL b2b_ctrl c=%0d: got %b want %b", c, obs & msk, exp & msk);
         end
         if (ld) begin
            dexp = (c == 1) ? 8'h2C : (c == 9) ? 8'hF8 : (c == 17) ? 8'h1F : 8'hFF;
            n_assert++;
            if (o_data !== dexp) begin
               n_fail++;
               $display("FAIL b2b_data c=%0d: got %h want %h", c, o_data, dexp);
            end
         end
         if (c == 0) begin
            i_data = 8'hF8; i_dc = 1'b1; i_last = 1'b0;
         end else if (c == 1) begin
            i_data = 8'h1F; i_dc = 1'b1; i_last = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
      end
      n_assert++;
      if (bv_cnt != 24) begin
         n_fail++;
         $display("FAIL b2b_bitvalid_len: got %0d want 24", bv_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  bytes [6];
      logic [6:0]  exp, msk;
      logic        ld, sh, cs, bv, busy, rdy, dcx, will_push;
      logic [7:0]  dexp;
      int unsigned j = 0;
      int unsigned k;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
      i_valid = 1'b1; i_data = bytes[0]; i_dc = 1'b0; i_last = 1'b0;
      will_push = o_ready;
      for (int c = 0; c <= 50; c++) begin
         @(negedge clk);
         ld   = (c >= 1) && (c <= 49) && (((c - 1) % 8) == 0);
         sh   = (c >= 1) && (c <= 49);
         cs   = !((c >= 1) && (c <= 48));
         bv   = (c >= 2) && (c <= 49);
         busy = (c <= 49);
         rdy  = (c <= 3) || (c == 10) || (c >= 18);
         k    = (c >= 1) ? (c - 1) / 8 : 0;
         dcx  = (ld && c < 49) ? k[0] : 1'b1;
         exp  = {ld, sh, cs, dcx, bv, busy, rdy};
         msk  = (ld || c == 0 || c == 50) ? 7'h7F : 7'h77;
         n_assert++;
         if ((obs & msk) !== (exp & msk)) begin
            n_fail++;
            $display("FAIL bp_ctrl c=%0d: got %b want %b", c, obs & msk, exp & msk);
         end
         if (ld) begin
            dexp = (c < 49) ? bytes[k] : 8'hFF;
            n_assert++;
            if (o_data !== dexp) begin
               n_fail++;
               $display("FAIL bp_data c=%0d: got %h want %h", c, o_data, dexp);
            end
         end
         if (will_push) j++;
         if (j < 6) begin
            i_valid = 1'b1; i_data = bytes[j]; i_dc = j[0]; i_last = (j == 5);
         end else begin
            i_valid = 1'b0;
         end
         will_push = i_valid && o_ready;
      end
      n_assert++;
      if (j != 6) begin
         n_fail++;
         $display("FAIL bp_push_count: got %0d want 6", j);
      end
   endtask

   task automatic test_hold_timeout();
      logic [6:0]  exp, msk;
      logic        ld, sh, cs, bv, busy;
      int unsigned wait_cnt = 0;
      i_valid = 1'b1; i_data = 8'h36; i_dc = 1'b1; i_last = 1'b0;
      for (int c = 0; c <= 74; c++) begin
         @(negedge clk);
         if (c == 0) i_valid = 1'b0;
         ld   = (c == 1) || (c == 73);
         sh   = ((c >= 1) && (c <= 8)) || (c == 73);
         cs   = !((c >= 1) && (c <= 72));
         bv   = (c >= 2) && (c <= 9);
         busy = (c <= 73);
         exp  = {ld, sh, cs, 1'b1, bv, busy, 1'b1};
         msk  = (ld || c == 0 || c == 74) ? 7'h7F : 7'h77;
         if (o_cs === 1'b0 && o_shift_en === 1'b0 && o_load === 1'b0) wait_cnt++;
         n_assert++;
         if ((obs & msk) !== (exp & msk)) begin
            n_fail++;
            $display("FAIL hold_ctrl c=%0d: got %b want %b", c, obs & msk, exp & msk);
         end
         if (ld) begin
            n_assert++;
            if (o_data !== ((c == 1) ? 8'h36 : 8'hFF)) begin
               n_fail++;
               $display("FAIL hold_data c=%0d: got %h want %h", c, o_data,
                        (c == 1) ? 8'h36 : 8'hFF);
            end
         end
      end
      n_assert++;
      if (wait_cnt != 64) begin
         n_fail++;
         $display("FAIL hold_wait_len: got %0d want 64", wait_cnt);
      end
   endtask

   task automatic test_wait_resume();
      logic [6:0] exp, msk;
      logic       ld, sh, cs, bv, busy;
      logic [7:0] dexp;
      i_valid = 1'b1; i_data = 8'h36; i_dc = 1'b1; i_last = 1'b0;
      for (int c = 0; c <= 30; c++) begin
         @(negedge clk);
         ld   = (c == 1) || (c == 21) || (c == 29);
         sh   = ((c >= 1) && (c <= 8)) || ((c >= 21) && (c <= 29));
         cs   = !((c >= 1) && (c <= 28));
         bv   = ((c >= 2) && (c <= 9)) || ((c >= 22) && (c <= 29));
         busy = (c <= 29);
         exp  = {ld, sh, cs, 1'b1, bv, busy, 1'b1};
         msk  = (ld || c == 0 || c == 30) ? 7'h7F : 7'h77;
         n_assert++;
         if ((obs & msk) !== (exp & msk)) begin
            n_fail++;
            $display("FAIL resume_ctrl c=%0d: got %b want %b", c, obs & msk, exp & msk);
         end
         if (ld) begin
            dexp = (c == 1) ? 8'h36 : (c == 21) ? 8'h48 : 8'hFF;
            n_assert++;
            if (o_data !== dexp) begin
               n_fail++;
               $display("FAIL resume_data c=%0d: got %h want %h", c, o_data, dexp);
            end
         end
         if (c == 19) begin
            i_valid = 1'b1; i_data = 8'h48; i_dc = 1'b1; i_last = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_byte();
      i_valid = 1'b1; i_data = 8'hA1; i_dc = 1'b0; i_last = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         if (c == 0) begin
            i_data = 8'hB2;
         end else if (c == 1) begin
            i_data = 8'hC3; i_dc = 1'b1; i_last = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
      end
      n_assert++;
      if ((obs & 7'h77) !== 7'b0100111) begin
         n_fail++;
         $display("FAIL rstmid_pre: got %b want %b", obs & 7'h77, 7'b0100111);
      end
      #1 rst = 1'b0;
      #1;
      n_assert++;
      if (obs !== 7'b0011001) begin
         n_fail++;
         $display("FAIL rstmid_now: got %b want %b", obs, 7'b0011001);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_assert++;
         if (obs !== 7'b0011001 || o_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL rstmid_after c=%0d: got %b/%h want %b/ff", c, obs, o_data,
                     7'b0011001);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_hold_timeout();
      test_wait_resume();
      test_reset_mid_byte();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
